// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared constants and types for the Winograd transform blocks
// Purpose: FSM state encodings, lane-mode constant and completion level
// constants used by the transform stages. No ports.
package win_pkg;

  typedef logic [15:0] lane_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ROW  = 2'd1;
  localparam logic [1:0] ST_COL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Lane mode: two independent 8-bit tiles packed in each 16-bit lane.
  localparam logic [1:0] MODE_8X8 = 2'b11;

  localparam logic Finish   = 1'b1;
  localparam logic UnFinish = 1'b0;

endpackage

// File: rtl/win33_atma_if.sv
// rtl/win33_atma_if.sv - request/result bundle of the Winograd output transform
// Purpose: groups the start handshake, tile inputs and result outputs.
// Ports (signals):
//   enable, bitwidth[1:0], m_row0..m_row3[63:0]  : request side (master drives)
//   y[63:0], busy, end_signal                   : result side (slave drives)
interface win33_atma_if;
  logic        enable;
  logic [1:0]  bitwidth;
  logic [63:0] m_row0;
  logic [63:0] m_row1;
  logic [63:0] m_row2;
  logic [63:0] m_row3;
  logic [63:0] y;
  logic        busy;
  logic        end_signal;

  modport master (
    output enable, bitwidth, m_row0, m_row1, m_row2, m_row3,
    input  y, busy, end_signal
  );

  modport slave (
    input  enable, bitwidth, m_row0, m_row1, m_row2, m_row3,
    output y, busy, end_signal
  );
endinterface

// File: rtl/win_lane_addsub3.sv
// rtl/win_lane_addsub3.sv - combinational three-operand lane adder a +/- b +/- c
// Purpose: r = a (+|-) b (+|-) c with wrap-around, optionally split into two
// independent 8-bit lanes with no carry from bit 7 into bit 8.
// Ports:
//   a, b, c [15:0] : operands
//   sub_b, sub_c   : 1 selects subtraction of b / c
//   split          : 1 selects dual 8-bit arithmetic
//   r [15:0]       : result
module win_lane_addsub3
  import win_pkg::*;
(
  input  lane_t a,
  input  lane_t b,
  input  lane_t c,
  input  logic  sub_b,
  input  logic  sub_c,
  input  logic  split,
  output lane_t r
);

  lane_t      b_t;
  lane_t      c_t;
  lane_t      full;
  logic [7:0] hi;

  always_comb begin
    b_t  = sub_b ? (16'd0 - b) : b;
    c_t  = sub_c ? (16'd0 - c) : c;
    full = a + b_t + c_t;
    // The low byte of the 16-bit sum is already the correct 8-bit result;
    // only the high byte must be recomputed without the low-byte carries.
    hi   = a[15:8]
         + (sub_b ? (8'd0 - b[15:8]) : b[15:8])
         + (sub_c ? (8'd0 - c[15:8]) : c[15:8]);
    r    = split ? {hi, full[7:0]} : full;
  end

endmodule

// File: rtl/win33_atma.sv
// rtl/win33_atma.sv - Winograd F(2x2,3x3) output transform Y = At * M * A
// Purpose: captures a 4x4 tile M, runs a row pass then a column pass with
// At = [1 1 1 0; 0 1 -1 -1], and presents the 2x2 result with a done pulse.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : win33_atma_if.slave (enable, bitwidth, m_row0..3 in; y, busy,
//          end_signal out)
module win33_atma
  import win_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  win33_atma_if.slave  bus
);

  logic [1:0]        state_q, state_d;
  logic [3:0][63:0]  m_q, m_d;
  logic [1:0]        mode_q, mode_d;
  lane_t [7:0]       t_q, t_d;
  logic [63:0]       y_q, y_d;
  logic              end_signal_q, end_signal_d;

  // t_row[0..3] = t0_j, t_row[4..7] = t1_j
  lane_t [7:0]       t_row;
  // y_col = {y11, y10, y01, y00}
  lane_t [3:0]       y_col;
  logic              split;

  // Mode is taken from the captured copy so a tile keeps its mode for both
  // passes regardless of what bitwidth does meanwhile.
  assign split = (mode_q == MODE_8X8);

  genvar j;
  generate
    for (j = 0; j < 4; j++) begin : g_row
      win_lane_addsub3 u_t0 (
        .a     (m_q[0][16*j +: 16]),
        .b     (m_q[1][16*j +: 16]),
        .c     (m_q[2][16*j +: 16]),
        .sub_b (1'b0),
        .sub_c (1'b0),
        .split (split),
        .r     (t_row[j])
      );
      win_lane_addsub3 u_t1 (
        .a     (m_q[1][16*j +: 16]),
        .b     (m_q[2][16*j +: 16]),
        .c     (m_q[3][16*j +: 16]),
        .sub_b (1'b1),
        .sub_c (1'b1),
        .split (split),
        .r     (t_row[4+j])
      );
    end

    // Row i of t feeds output row i: y_i0 = sum of first three, y_i1 = the
    // second At row applied along the same t row.
    for (j = 0; j < 2; j++) begin : g_col
      win_lane_addsub3 u_y0 (
        .a     (t_q[4*j]),
        .b     (t_q[4*j+1]),
        .c     (t_q[4*j+2]),
        .sub_b (1'b0),
        .sub_c (1'b0),
        .split (split),
        .r     (y_col[2*j])
      );
      win_lane_addsub3 u_y1 (
        .a     (t_q[4*j+1]),
        .b     (t_q[4*j+2]),
        .c     (t_q[4*j+3]),
        .sub_b (1'b1),
        .sub_c (1'b1),
        .split (split),
        .r     (y_col[2*j+1])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    mode_d       = mode_q;
    t_d          = t_q;
    y_d          = y_q;
    end_signal_d = UnFinish;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          m_d     = {bus.m_row3, bus.m_row2, bus.m_row1, bus.m_row0};
          mode_d  = bus.bitwidth;
          state_d = ST_ROW;
        end
      end
      ST_ROW: begin
        t_d     = t_row;
        state_d = ST_COL;
      end
      ST_COL: begin
        y_d     = y_col;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Registered pulse: visible in the cycle after leaving DONE, when the
        // FSM is already back in IDLE.
        end_signal_d = Finish;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      m_q          <= '0;
      mode_q       <= 2'b00;
      t_q          <= '0;
      y_q          <= '0;
      end_signal_q <= UnFinish;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      mode_q       <= mode_d;
      t_q          <= t_d;
      y_q          <= y_d;
      end_signal_q <= end_signal_d;
    end
  end

  assign bus.y          = y_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.end_signal = end_signal_q;

endmodule

// File: tb/tb_win33_atma.sv
// tb/tb_win33_atma.sv - self-checking bench for the Winograd output transform
module tb_win33_atma;

  typedef struct {
    logic [63:0] y;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_end = 0;
  exp_t sb[$];

  win33_atma_if bus();

  win33_atma dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.end_signal === 1'b1) n_end <= n_end + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: Y = At * M * At^T evaluated as full integer sums, then wrapped.
  function automatic logic [63:0] model(input logic [63:0] r0, input logic [63:0] r1,
                                        input logic [63:0] r2, input logic [63:0] r3,
                                        input logic [1:0] bw);
    int          at [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
    logic [63:0] rows [4];
    logic [63:0] res;
    logic [15:0] e;
    int          acc, acc_lo, acc_hi, coef, idx;
    rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
    res = '0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        acc = 0; acc_lo = 0; acc_hi = 0;
        for (int r = 0; r < 4; r++) begin
          for (int l = 0; l < 4; l++) begin
            coef   = at[i][r] * at[k][l];
            e      = rows[r][16*l +: 16];
            acc    = acc + coef * int'(e);
            acc_lo = acc_lo + coef * int'(e[7:0]);
            acc_hi = acc_hi + coef * int'(e[15:8]);
          end
        end
        idx = 2 * i + k;
        res[16*idx +: 16] = (bw == 2'b11) ? {acc_hi[7:0], acc_lo[7:0]} : acc[15:0];
      end
    end
    return res;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic set_tile(input logic [63:0] r0, input logic [63:0] r1,
                          input logic [63:0] r2, input logic [63:0] r3, input logic [1:0] bw);
    bus.m_row0 = r0; bus.m_row1 = r1; bus.m_row2 = r2; bus.m_row3 = r3;
    bus.bitwidth = bw;
  endtask

  // Called at posedge+1 with the DUT idle; the next edge accepts the tile.
  task automatic push_tile(input logic [63:0] r0, input logic [63:0] r1,
                           input logic [63:0] r2, input logic [63:0] r3,
                           input logic [1:0] bw, input logic [63:0] exp_y);
    exp_t e;
    set_tile(r0, r1, r2, r3, bw);
    bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    e.y   = exp_y;
    e.cyc = cyc + 3;
    sb.push_back(e);
    set_tile(rnd64(), rnd64(), rnd64(), rnd64(), ~bw);
  endtask

  task automatic wait_end(output logic [63:0] y, output int c, output bit seen);
    seen = 1'b0; y = '0; c = -1;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (bus.end_signal === 1'b1) begin
        seen = 1'b1; y = bus.y; c = cyc;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b1;
    set_tile(rnd64(), rnd64(), rnd64(), rnd64(), 2'($urandom_range(0, 3)));
    bus.enable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.y, bus.end_signal, bus.busy} !== 66'b0) begin
        n_bad++;
        $display("FAIL reset_state: y=%h end=%b busy=%b want 0/0/0", bus.y, bus.end_signal, bus.busy);
      end
    end
    @(posedge clk); #1;
    bus.enable = 1'b0;
    rst = 1'b0;
    base = n_end;
    repeat (6) begin
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.y !== 64'h0) begin
        n_bad++;
        $display("FAIL reset_idle: busy=%b y=%h want 0/0", bus.busy, bus.y);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (n_end !== base) begin
      n_bad++;
      $display("FAIL reset_no_end: pulses=%0d want 0", n_end - base);
    end
  endtask

  task automatic test_fixed(input string name, input logic [63:0] r0, input logic [63:0] r1,
                            input logic [63:0] r2, input logic [63:0] r3,
                            input logic [1:0] bw, input logic [63:0] exp_y);
    logic [63:0] gy;
    int          gc;
    bit          seen;
    exp_t        e;
    push_tile(r0, r1, r2, r3, bw, exp_y);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_busy: busy=%b want 1", name, bus.busy);
    end
    wait_end(gy, gc, seen);
    n_cmp++;
    if (!seen || sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s_end: seen=%0d queued=%0d want 1/1", name, seen, sb.size());
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (gy !== e.y) begin
        n_bad++;
        $display("FAIL %s_y: got %h want %h", name, gy, e.y);
      end
      n_cmp++;
      if (gc !== e.cyc) begin
        n_bad++;
        $display("FAIL %s_latency: end at cycle %0d want %0d", name, gc, e.cyc);
      end
    end
  endtask

  task automatic test_all_ones();
    test_fixed("all_ones", {4{16'h0001}}, {4{16'h0001}}, {4{16'h0001}}, {4{16'h0001}},
               2'b00, 64'h0001_FFFD_FFFD_0009);
  endtask

  task automatic test_wrap();
    test_fixed("wrap16", {4{16'h7FFF}}, 64'h0, 64'h0, 64'h0, 2'b00, 64'h0000_0000_8001_7FFD);
  endtask

  task automatic test_dual8();
    test_fixed("dual8", {4{16'h0201}}, {4{16'h0201}}, {4{16'h0201}}, {4{16'h0201}},
               2'b11, 64'h0201_FAFD_FAFD_1209);
  endtask

  task automatic test_random();
    logic [63:0] r [4];
    logic [1:0]  bw;
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 4; j++) r[j] = rnd64();
      bw = 2'(n);
      test_fixed("random", r[0], r[1], r[2], r[3], bw, model(r[0], r[1], r[2], r[3], bw));
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [63:0] r [4];
    logic [1:0]  bw;
    int          pushed = 0;
    int          got = 0;
    int          base = n_end;
    for (int k = 0; k < 26; k++) begin
      if (k <= 16) begin
        for (int j = 0; j < 4; j++) r[j] = rnd64();
        bw = (((k % 2) ^ ((k / 4) % 2)) != 0) ? 2'b11 : 2'b01;
        set_tile(r[0], r[1], r[2], r[3], bw);
        bus.enable = 1'b1;
        if (k % 4 == 0) begin
          e.y   = model(r[0], r[1], r[2], r[3], bw);
          e.cyc = cyc + 4;
          sb.push_back(e);
          pushed++;
        end
      end else begin
        bus.enable = 1'b0;
      end
      @(negedge clk);
      if (bus.end_signal === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b2b_spurious_end: end at cycle %0d with nothing queued", cyc);
        end else begin
          e = sb.pop_front();
          got++;
          n_cmp++;
          if (bus.y !== e.y) begin
            n_bad++;
            $display("FAIL b2b_y: got %h want %h", bus.y, e.y);
          end
          n_cmp++;
          if (cyc !== e.cyc) begin
            n_bad++;
            $display("FAIL b2b_latency: end at cycle %0d want %0d", cyc, e.cyc);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (got !== pushed || sb.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_count: results %0d want %0d", got, pushed);
    end
    n_cmp++;
    if (n_end - base !== pushed) begin
      n_bad++;
      $display("FAIL b2b_pulses: pulses %0d want %0d", n_end - base, pushed);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    for (int s = 1; s <= 2; s++) begin
      set_tile(rnd64(), rnd64(), rnd64(), rnd64(), 2'b00);
      bus.enable = 1'b1;
      @(posedge clk); #1;
      bus.enable = 1'b0;
      // s=1 lands in COL, s=2 lands in DONE
      repeat (s) begin
        @(posedge clk); #1;
      end
      base = n_end;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.y, bus.end_signal, bus.busy} !== 66'b0) begin
        n_bad++;
        $display("FAIL reset_mid_state: y=%h end=%b busy=%b want 0/0/0", bus.y, bus.end_signal, bus.busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      n_cmp++;
      if (n_end !== base || bus.y !== 64'h0) begin
        n_bad++;
        $display("FAIL reset_mid_abort: pulses=%0d y=%h want 0/0", n_end - base, bus.y);
      end
    end
    test_fixed("after_reset", {4{16'h0001}}, {4{16'h0001}}, {4{16'h0001}}, {4{16'h0001}},
               2'b00, 64'h0001_FFFD_FFFD_0009);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    set_tile(64'h0, 64'h0, 64'h0, 64'h0, 2'b00);
    test_reset();
    test_all_ones();
    test_wrap();
    test_dual8();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
